// File: rtl/delay_path_probe_ctrl_if.sv
// Signal bundle between the measurement host / delay path and delay_path_probe_ctrl.
// The slave modport is the controller's view; master is the host/path side.
interface delay_path_probe_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int WAIT_W = 8
);
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  trials;
  logic [WAIT_W-1:0] settle_cycles;
  logic [1:0]        ht_mode;
  logic              exp_invert;
  logic              path_in;
  logic              path_out;
  logic              ht_in1;
  logic              ht_in2;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  trial_count;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  first_err_idx;

  modport master (
    output start, abort, trials, settle_cycles, ht_mode, exp_invert, path_out,
    input  path_in, ht_in1, ht_in2, busy, done, trial_count, err_count, first_err_idx
  );

  modport slave (
    input  start, abort, trials, settle_cycles, ht_mode, exp_invert, path_out,
    output path_in, ht_in1, ht_in2, busy, done, trial_count, err_count, first_err_idx
  );
endinterface

// File: rtl/delay_path_probe_ctrl.sv
// Trial sequencer for a single instrumented delay path with a two-input trigger gate.
// Optional macro PATH_OUT_SYNC_EN inserts a 2-flop synchronizer on path_out.
module delay_path_probe_ctrl #(
  parameter int CNT_W  = 16,
  parameter int WAIT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  delay_path_probe_ctrl_if.slave io
);

  localparam int WC_W = WAIT_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, next_state;

  // Run configuration, captured on an accepted start
  logic [CNT_W-1:0]  trials_q;
  logic [WAIT_W-1:0] settle_q;
  logic [1:0]        mode_q;
  logic              exp_inv_q;

  logic [WC_W-1:0]   wait_cnt, wait_cnt_d, wait_load;
  logic [WAIT_W-1:0] settle_eff;

  logic              lvl, lvl_d;
  logic              path_in_q;
  logic [1:0]        ht_q, ht_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  tcnt, tcnt_d, tcnt_inc;
  logic [CNT_W-1:0]  ecnt, ecnt_d;
  logic [CNT_W-1:0]  fidx, fidx_d;

  logic              accept;
  logic              sample;
  logic              mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

`ifdef PATH_OUT_SYNC_EN
  localparam int WAIT_EXTRA = 2;

  logic path_out_p0, path_out_p1;

  // Synchronizer stages: p0 then p1 feeds the compare
  always_ff @(posedge clk) begin
    path_out_p0 <= io.path_out;
    path_out_p1 <= path_out_p0;
  end

  assign sample = path_out_p1;
`else
  localparam int WAIT_EXTRA = 0;

  assign sample = io.path_out;
`endif

  assign accept     = (state == S_IDLE) && io.start && !io.abort;
  assign settle_eff = (settle_q == '0) ? WAIT_W'(1) : settle_q;
  // Synchronizer latency is absorbed into WAIT so the sample point stays put
  assign wait_load  = WC_W'(settle_eff) + WC_W'(WAIT_EXTRA);
  assign tcnt_inc   = tcnt + CNT_W'(1);
  assign mismatch   = sample != (path_in_q ^ exp_inv_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (io.trials == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH:  next_state = S_WAIT;
      S_WAIT: begin
        if (wait_cnt <= WC_W'(1)) begin
          next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: next_state = (tcnt_inc == trials_q) ? S_DONE : S_LAUNCH;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (io.abort) begin
      next_state = S_IDLE;
    end
  end

  always_comb begin
    lvl_d      = lvl;
    wait_cnt_d = wait_cnt;
    tcnt_d     = tcnt;
    ecnt_d     = ecnt;
    fidx_d     = fidx;
    if (io.abort) begin
      if (state != S_IDLE) begin
        lvl_d = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            tcnt_d = '0;
            ecnt_d = '0;
            fidx_d = '1;
          end
        end
        S_LAUNCH: begin
          lvl_d      = ~lvl;
          wait_cnt_d = wait_load;
        end
        S_WAIT: wait_cnt_d = wait_cnt - WC_W'(1);
        S_CAPTURE: begin
          tcnt_d = tcnt_inc;
          if (mismatch) begin
            ecnt_d = sat_inc(ecnt);
            if (ecnt == '0) begin
              fidx_d = tcnt;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (next_state != S_IDLE);
    done_d = (next_state == S_DONE);
    // On the accepting cycle the latched mode is not yet visible, so use the input
    if (next_state == S_IDLE) begin
      ht_d = 2'b00;
    end else if (state == S_IDLE) begin
      ht_d = io.ht_mode;
    end else begin
      ht_d = mode_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl       <= 1'b0;
      path_in_q <= 1'b0;
      ht_q      <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tcnt      <= '0;
      ecnt      <= '0;
      fidx      <= '1;
    end else begin
      lvl       <= lvl_d;
      path_in_q <= lvl_d;
      ht_q      <= ht_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tcnt      <= tcnt_d;
      ecnt      <= ecnt_d;
      fidx      <= fidx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      trials_q  <= io.trials;
      settle_q  <= io.settle_cycles;
      mode_q    <= io.ht_mode;
      exp_inv_q <= io.exp_invert;
    end
    wait_cnt <= wait_cnt_d;
  end

  assign io.path_in       = path_in_q;
  assign io.ht_in1        = ht_q[0];
  assign io.ht_in2        = ht_q[1];
  assign io.busy          = busy_q;
  assign io.done          = done_q;
  assign io.trial_count   = tcnt;
  assign io.err_count     = ecnt;
  assign io.first_err_idx = fidx;

endmodule

// File: tb/tb_delay_path_probe_ctrl.sv
// Directed bench for delay_path_probe_ctrl with a behavioural delay-path model.
module tb_delay_path_probe_ctrl;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 8;
  localparam int LIMIT  = 2000;

`ifdef PATH_OUT_SYNC_EN
  localparam int PER_EXTRA = 4;
`else
  localparam int PER_EXTRA = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;

  delay_path_probe_ctrl_if #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) io ();

  delay_path_probe_ctrl #(.CNT_W(CNT_W), .WAIT_W(WAIT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  always #5 clk = ~clk;

  // Delay path: path_out = path_in delayed, optionally inverted unless trigger is 11
  logic [7:0] dl = '0;
  logic [2:0] pd_idx = 3'd2;
  logic       inv_model = 1'b0;

  always @(posedge clk) dl <= {dl[6:0], io.path_in};
  assign io.path_out = dl[pd_idx] ^ (inv_model && ({io.ht_in2, io.ht_in1} != 2'b11));

  typedef struct {
    int         trials;
    int         settle;
    logic [1:0] mode;
    logic       exp_inv;
    int         delay;
    logic       inv_model;
    int         exp_err;
    int         exp_first;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   cur_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL run%0d %s: got %0h expected %0h", cur_run, name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_path_in", 32'(io.path_in), 32'd0);
    check("rst_ht", 32'({io.ht_in2, io.ht_in1}), 32'd0);
    check("rst_busy", 32'(io.busy), 32'd0);
    check("rst_done", 32'(io.done), 32'd0);
    check("rst_trial_count", 32'(io.trial_count), 32'd0);
    check("rst_err_count", 32'(io.err_count), 32'd0);
    check("rst_first_err_idx", 32'(io.first_err_idx), 32'h0000FFFF);
  endtask

  task automatic do_run(input vec_t v);
    int   cyc;
    int   s_eff;
    bit   ht_ok;
    logic pin0;
    pd_idx    = 3'(v.delay - 1);
    inv_model = v.inv_model;
    @(negedge clk);
    io.trials        = 16'(v.trials);
    io.settle_cycles = 8'(v.settle);
    io.ht_mode       = v.mode;
    io.exp_invert    = v.exp_inv;
    io.start         = 1'b1;
    pin0 = io.path_in;
    @(negedge clk);
    io.start = 1'b0;
    cyc   = 0;
    ht_ok = 1'b1;
    while (!io.done && cyc < LIMIT) begin
      if (!io.busy || {io.ht_in2, io.ht_in1} != v.mode) ht_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!io.busy || {io.ht_in2, io.ht_in1} != v.mode) ht_ok = 1'b0;
    s_eff = (v.settle == 0) ? 1 : v.settle;
    check("done_latency", 32'(cyc), 32'(v.trials * (s_eff + PER_EXTRA)));
    check("ht_busy_during_run", 32'(ht_ok), 32'd1);
    check("trial_count", 32'(io.trial_count), 32'(v.trials));
    check("err_count", 32'(io.err_count), 32'(v.exp_err));
    check("first_err_idx", 32'(io.first_err_idx), 32'(v.exp_first));
    if (v.trials == 0) check("path_in_hold", 32'(io.path_in), 32'(pin0));
    @(negedge clk);
    check("post_done_busy", 32'(io.busy), 32'd0);
    check("post_done_done", 32'(io.done), 32'd0);
    check("post_done_ht", 32'({io.ht_in2, io.ht_in1}), 32'd0);
  endtask

  initial begin
    vec_t rv;
    bit   quiet;
    int   cyc;

    //           trials settle mode  inv   dly  invm  err  first
    vecs[0] = '{8,     4,     2'b11, 1'b0, 3,   1'b0, 0,   'hFFFF};
    vecs[1] = '{8,     4,     2'b11, 1'b1, 3,   1'b0, 8,   0};
    vecs[2] = '{5,     4,     2'b11, 1'b0, 3,   1'b1, 0,   'hFFFF};
    vecs[3] = '{5,     4,     2'b01, 1'b0, 3,   1'b1, 5,   0};
    vecs[4] = '{4,     2,     2'b00, 1'b0, 6,   1'b0, 4,   0};
    vecs[5] = '{4,     0,     2'b00, 1'b0, 3,   1'b0, 4,   0};
    vecs[6] = '{0,     4,     2'b10, 1'b0, 3,   1'b0, 0,   'hFFFF};

    rst_n            = 1'b0;
    io.start         = 1'b0;
    io.abort         = 1'b0;
    io.trials        = '0;
    io.settle_cycles = '0;
    io.ht_mode       = 2'b00;
    io.exp_invert    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      cur_run = i;
      do_run(vecs[i]);
      repeat (2) @(negedge clk);
    end

    // Abort in WAIT of trial 3, with a stray start while busy
    cur_run   = 10;
    pd_idx    = 3'd2;
    inv_model = 1'b0;
    io.trials = 16'd8; io.settle_cycles = 8'd4; io.ht_mode = 2'b11; io.exp_invert = 1'b0;
    io.start  = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    repeat (5) @(negedge clk);
    io.start = 1'b1; io.trials = 16'd1;
    @(negedge clk);
    io.start = 1'b0; io.trials = 16'd8;
    repeat (8) @(negedge clk);
    check("busy_before_abort", 32'(io.busy), 32'd1);
    io.abort = 1'b1;
    @(negedge clk);
    io.abort = 1'b0;
    check("abort_busy", 32'(io.busy), 32'd0);
    check("abort_done", 32'(io.done), 32'd0);
    check("abort_path_in", 32'(io.path_in), 32'd0);
    check("abort_ht", 32'({io.ht_in2, io.ht_in1}), 32'd0);
    check("abort_trial_count", 32'(io.trial_count), 32'd2);
    check("abort_err_count", 32'(io.err_count), 32'd0);
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (io.done || io.busy) quiet = 1'b0;
    end
    check("abort_stays_idle", 32'(quiet), 32'd1);

    // start and abort together in IDLE
    cur_run  = 11;
    io.start = 1'b1; io.abort = 1'b1;
    @(negedge clk);
    io.start = 1'b0; io.abort = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      if (io.done || io.busy) quiet = 1'b0;
      @(negedge clk);
    end
    check("start_abort_idle", 32'(quiet), 32'd1);
    check("start_abort_counts_held", 32'(io.trial_count), 32'd2);

    // Reset mid-run with errors accumulated
    cur_run = 12;
    io.trials = 16'd8; io.settle_cycles = 8'd4; io.ht_mode = 2'b10; io.exp_invert = 1'b1;
    io.start  = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    repeat (14) @(negedge clk);
    check("pre_reset_err_count", 32'(io.err_count), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_outputs();
    cyc = 0;
    while (io.busy && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end

    // First launch after reset must drive 1
    cur_run = 13;
    rv = '{1, 1, 2'b11, 1'b0, 3, 1'b0, 1, 0};
    do_run(rv);
    check("post_reset_launch_level", 32'(io.path_in), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
